// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle CPU control unit: opcode values,
// state encodings, ALUOp / RegDst / PCSrc codes and an opcode classifier.
// Imported by the control unit, its decode sub-block and the datapath.
package multicycle_ctrl_fsm_pkg;

  localparam int OPW = 6;
  localparam int STW = 3;

  localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB  = 6'b000001;
  localparam logic [OPW-1:0] OP_ADDI = 6'b000010;
  localparam logic [OPW-1:0] OP_OR   = 6'b010000;
  localparam logic [OPW-1:0] OP_AND  = 6'b010001;
  localparam logic [OPW-1:0] OP_ORI  = 6'b010010;
  localparam logic [OPW-1:0] OP_SLL  = 6'b011000;
  localparam logic [OPW-1:0] OP_SLT  = 6'b100110;
  localparam logic [OPW-1:0] OP_SLTI = 6'b100111;
  localparam logic [OPW-1:0] OP_SW   = 6'b110000;
  localparam logic [OPW-1:0] OP_LW   = 6'b110001;
  localparam logic [OPW-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OPW-1:0] OP_J    = 6'b111000;
  localparam logic [OPW-1:0] OP_JR   = 6'b111001;
  localparam logic [OPW-1:0] OP_JAL  = 6'b111010;
  localparam logic [OPW-1:0] OP_HALT = 6'b111111;

  typedef enum logic [STW-1:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RD_R31 = 2'b00;
  localparam logic [1:0] RD_RT  = 2'b01;
  localparam logic [1:0] RD_RD  = 2'b10;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JR   = 2'b10;
  localparam logic [1:0] PC_JUMP = 2'b11;

  typedef enum logic [2:0] {
    OC_ALU_R,
    OC_ALU_I,
    OC_LOAD,
    OC_STORE,
    OC_BRANCH,
    OC_JUMP,
    OC_HALT
  } opclass_e;

  // Any opcode not listed is deliberately folded into halt.
  function automatic opclass_e op_class(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT: return OC_ALU_R;
      OP_ADDI, OP_ORI, OP_SLTI:                      return OC_ALU_I;
      OP_LW:                                         return OC_LOAD;
      OP_SW:                                         return OC_STORE;
      OP_BEQ:                                        return OC_BRANCH;
      OP_J, OP_JR, OP_JAL:                           return OC_JUMP;
      default:                                       return OC_HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the control unit and the datapath.
//   master : control unit (drives selects/enables, reads opcode and zero)
//   slave  : datapath (drives opcode and zero, reads selects/enables)
interface multicycle_ctrl_fsm_if;
  import multicycle_ctrl_fsm_pkg::*;

  logic [OPW-1:0] opcode;
  logic           zero;
  logic           PCWre;
  logic           IRWre;
  logic           ExtSel;
  logic           ALUSrcA;
  logic           ALUSrcB;
  logic [2:0]     ALUOp;
  logic           mRD;
  logic           mWR;
  logic           DBDataSrc;
  logic           WrRegDSrc;
  logic           RegWre;
  logic [1:0]     RegDst;
  logic [1:0]     PCSrc;
  logic [STW-1:0] state;

  modport master (
    input  opcode, zero,
    output PCWre, IRWre, ExtSel, ALUSrcA, ALUSrcB, ALUOp, mRD, mWR,
           DBDataSrc, WrRegDSrc, RegWre, RegDst, PCSrc, state
  );

  modport slave (
    output opcode, zero,
    input  PCWre, IRWre, ExtSel, ALUSrcA, ALUSrcB, ALUOp, mRD, mWR,
           DBDataSrc, WrRegDSrc, RegWre, RegDst, PCSrc, state
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_decode.sv
// Pure combinational decode: current state + opcode (+ ALU zero) to the
// datapath selects and enables. Anything not named for a state stays 0.
// Ports: i_state, i_opcode, i_zero in; o_* are the control outputs.
module multicycle_ctrl_fsm_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  state_e         i_state,
  input  logic [OPW-1:0] i_opcode,
  input  logic           i_zero,
  output logic           o_pcwre,
  output logic           o_irwre,
  output logic           o_extsel,
  output logic           o_alusrca,
  output logic           o_alusrcb,
  output logic [2:0]     o_aluop,
  output logic           o_mrd,
  output logic           o_mwr,
  output logic           o_dbdatasrc,
  output logic           o_wrregdsrc,
  output logic           o_regwre,
  output logic [1:0]     o_regdst,
  output logic [1:0]     o_pcsrc
);

  opclass_e w_cls;
  assign w_cls = op_class(i_opcode);

  always_comb begin
    o_pcwre     = 1'b0;
    o_irwre     = 1'b0;
    o_extsel    = 1'b0;
    o_alusrca   = 1'b0;
    o_alusrcb   = 1'b0;
    o_aluop     = ALU_ADD;
    o_mrd       = 1'b0;
    o_mwr       = 1'b0;
    o_dbdatasrc = 1'b0;
    o_wrregdsrc = 1'b0;
    o_regwre    = 1'b0;
    o_regdst    = RD_R31;
    o_pcsrc     = PC_SEQ;
    case (i_state)
      S_IF: o_irwre = 1'b1;
      S_ID: begin
        // Jumps finish in ID; jal also links PC+4 into $31 here.
        if (w_cls == OC_JUMP) begin
          o_pcwre = 1'b1;
          o_pcsrc = (i_opcode == OP_JR) ? PC_JR : PC_JUMP;
          if (i_opcode == OP_JAL) begin
            o_regwre    = 1'b1;
            o_regdst    = RD_R31;
            o_wrregdsrc = 1'b0;
          end
        end
      end
      S_EXE_AL: begin
        o_alusrcb = (w_cls == OC_ALU_I);
        o_extsel  = (i_opcode == OP_ADDI) || (i_opcode == OP_SLTI);
        o_alusrca = (i_opcode == OP_SLL);
        case (i_opcode)
          OP_SUB:        o_aluop = ALU_SUB;
          OP_OR, OP_ORI: o_aluop = ALU_OR;
          OP_AND:        o_aluop = ALU_AND;
          OP_SLL:        o_aluop = ALU_SLL;
          OP_SLT, OP_SLTI: o_aluop = ALU_SLT;
          default:       o_aluop = ALU_ADD;
        endcase
      end
      S_WB_AL: begin
        o_regwre    = 1'b1;
        o_wrregdsrc = 1'b1;
        o_dbdatasrc = 1'b0;
        o_regdst    = (w_cls == OC_ALU_R) ? RD_RD : RD_RT;
        o_pcwre     = 1'b1;
        o_pcsrc     = PC_SEQ;
      end
      S_EXE_BR: begin
        o_aluop = ALU_SUB;
        o_pcwre = 1'b1;
        o_pcsrc = i_zero ? PC_BR : PC_SEQ;
      end
      S_EXE_LS: begin
        o_aluop   = ALU_ADD;
        o_alusrcb = 1'b1;
        o_extsel  = 1'b1;
      end
      S_MEM: begin
        if (w_cls == OC_LOAD) begin
          o_mrd = 1'b1;
        end else begin
          o_mwr   = 1'b1;
          o_pcwre = 1'b1;
          o_pcsrc = PC_SEQ;
        end
      end
      S_WB_LD: begin
        o_regwre    = 1'b1;
        o_dbdatasrc = 1'b1;
        o_wrregdsrc = 1'b1;
        o_regdst    = RD_RT;
        o_pcwre     = 1'b1;
        o_pcsrc     = PC_SEQ;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control unit: state register, next-state logic and the
// reset gate on all control outputs. Decode lives in multicycle_ctrl_fsm_decode.
// Ports: CLK (rising edge), Reset (async, active high), ctrl (master side of
// multicycle_ctrl_fsm_if: opcode/zero in, selects/enables/state out).
//
// state    | meaning
// IF       | fetch, IR write
// ID       | decode; jumps complete here; halt/unknown opcodes park here
// EXE_AL   | ALU op for R/I arithmetic
// WB_AL    | ALU result to register file, PC+4
// EXE_BR   | beq compare, PC update
// EXE_LS   | address calc for lw/sw
// MEM      | data memory read (lw) or write + PC+4 (sw)
// WB_LD    | load data to register file, PC+4
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
(
  input logic                  CLK,
  input logic                  Reset,
  multicycle_ctrl_fsm_if.master ctrl
);

  state_e     r_state;
  opclass_e   w_cls;
  logic       w_pcwre, w_irwre, w_extsel, w_alusrca, w_alusrcb;
  logic [2:0] w_aluop;
  logic       w_mrd, w_mwr, w_dbdatasrc, w_wrregdsrc, w_regwre;
  logic [1:0] w_regdst, w_pcsrc;

  assign w_cls = op_class(ctrl.opcode);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IF;
    end else begin
      case (r_state)
        S_IF: r_state <= S_ID;
        S_ID: begin
          case (w_cls)
            OC_JUMP:           r_state <= S_IF;
            OC_HALT:           r_state <= S_ID;
            OC_BRANCH:         r_state <= S_EXE_BR;
            OC_LOAD, OC_STORE: r_state <= S_EXE_LS;
            default:           r_state <= S_EXE_AL;
          endcase
        end
        S_EXE_AL: r_state <= S_WB_AL;
        S_EXE_LS: r_state <= S_MEM;
        S_MEM:    r_state <= (w_cls == OC_LOAD) ? S_WB_LD : S_IF;
        default:  r_state <= S_IF;
      endcase
    end
  end

  multicycle_ctrl_fsm_decode u_decode (
    .i_state     (r_state),
    .i_opcode    (ctrl.opcode),
    .i_zero      (ctrl.zero),
    .o_pcwre     (w_pcwre),
    .o_irwre     (w_irwre),
    .o_extsel    (w_extsel),
    .o_alusrca   (w_alusrca),
    .o_alusrcb   (w_alusrcb),
    .o_aluop     (w_aluop),
    .o_mrd       (w_mrd),
    .o_mwr       (w_mwr),
    .o_dbdatasrc (w_dbdatasrc),
    .o_wrregdsrc (w_wrregdsrc),
    .o_regwre    (w_regwre),
    .o_regdst    (w_regdst),
    .o_pcsrc     (w_pcsrc)
  );

  // Reset forces every strobe low in the same cycle it rises, so an
  // aborted instruction can never complete a register or memory write.
  always_comb begin
    ctrl.PCWre     = 1'b0;
    ctrl.IRWre     = 1'b0;
    ctrl.ExtSel    = 1'b0;
    ctrl.ALUSrcA   = 1'b0;
    ctrl.ALUSrcB   = 1'b0;
    ctrl.ALUOp     = 3'b000;
    ctrl.mRD       = 1'b0;
    ctrl.mWR       = 1'b0;
    ctrl.DBDataSrc = 1'b0;
    ctrl.WrRegDSrc = 1'b0;
    ctrl.RegWre    = 1'b0;
    ctrl.RegDst    = 2'b00;
    ctrl.PCSrc     = 2'b00;
    ctrl.state     = r_state;
    if (!Reset) begin
      ctrl.PCWre     = w_pcwre;
      ctrl.IRWre     = w_irwre;
      ctrl.ExtSel    = w_extsel;
      ctrl.ALUSrcA   = w_alusrca;
      ctrl.ALUSrcB   = w_alusrcb;
      ctrl.ALUOp     = w_aluop;
      ctrl.mRD       = w_mrd;
      ctrl.mWR       = w_mwr;
      ctrl.DBDataSrc = w_dbdatasrc;
      ctrl.WrRegDSrc = w_wrregdsrc;
      ctrl.RegWre    = w_regwre;
      ctrl.RegDst    = w_regdst;
      ctrl.PCSrc     = w_pcsrc;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm. The driver computes, per
// instruction, the expected control word for every cycle from the opcode's
// instruction class and queues it; the monitor pops one entry per cycle on
// the falling edge and compares the fields that matter in that cycle.
module tb_multicycle_ctrl_fsm;

  logic CLK = 1'b0;
  logic Reset;
  multicycle_ctrl_fsm_if bus();

  multicycle_ctrl_fsm dut (.CLK(CLK), .Reset(Reset), .ctrl(bus));

  always #5 CLK = ~CLK;

  // Packed view: [19:17] state, 16 PCWre, 15 IRWre, 14 RegWre, 13 mRD,
  // 12 mWR, [11:9] ALUOp, 8 ALUSrcA, 7 ALUSrcB, 6 ExtSel, 5 DBDataSrc,
  // 4 WrRegDSrc, [3:2] RegDst, [1:0] PCSrc
  localparam int F_ALUOP = 9, F_SRCA = 8, F_SRCB = 7, F_EXT = 6;
  localparam int F_DB = 5, F_WR = 4, F_RD = 2, F_PCS = 0;
  localparam int HALT_HOLD = 20;

  typedef struct {
    logic [19:0] v;
    logic [19:0] m;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t seq[$];
  bit   seq_parks;
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic exp_t rec(input string tag, input logic [2:0] st,
                               input logic pcw, input logic irw, input logic rgw,
                               input logic rd, input logic wr);
    exp_t e;
    e.v   = {st, pcw, irw, rgw, rd, wr, 12'b0};
    e.m   = {8'hFF, 12'b0};
    e.tag = tag;
    return e;
  endfunction

  function automatic exp_t put(input exp_t e, input int lo, input int w, input logic [2:0] val);
    exp_t r = e;
    for (int i = 0; i < w; i++) begin
      r.v[lo+i] = val[i];
      r.m[lo+i] = 1'b1;
    end
    return r;
  endfunction

  function automatic exp_t reset_rec(input string tag);
    exp_t e;
    e.v   = '0;
    e.m   = '1;
    e.tag = tag;
    return e;
  endfunction

  // Reference model: expected cycle-by-cycle control words for one instruction.
  function automatic void model(input logic [5:0] op, input logic z);
    exp_t e;
    logic [2:0] aop;
    logic sa, sb, ex, rtype, alu;
    seq.delete();
    seq_parks = 1'b0;
    seq.push_back(rec("IF", 3'b000, 0, 1, 0, 0, 0));
    alu = 1'b1; aop = 3'b000; sa = 0; sb = 0; ex = 0; rtype = 1;
    case (op)
      6'b000000: aop = 3'b000;
      6'b000001: aop = 3'b001;
      6'b000010: begin aop = 3'b000; sb = 1; ex = 1; rtype = 0; end
      6'b010000: aop = 3'b010;
      6'b010001: aop = 3'b011;
      6'b010010: begin aop = 3'b010; sb = 1; rtype = 0; end
      6'b011000: begin aop = 3'b100; sa = 1; end
      6'b100110: aop = 3'b101;
      6'b100111: begin aop = 3'b101; sb = 1; ex = 1; rtype = 0; end
      default:   alu = 1'b0;
    endcase
    if (alu) begin
      seq.push_back(rec("ID_alu", 3'b001, 0, 0, 0, 0, 0));
      e = rec("EXE_AL", 3'b110, 0, 0, 0, 0, 0);
      e = put(e, F_ALUOP, 3, aop);
      e = put(e, F_SRCA, 1, {2'b0, sa});
      e = put(e, F_SRCB, 1, {2'b0, sb});
      e = put(e, F_EXT, 1, {2'b0, ex});
      seq.push_back(e);
      e = rec("WB_AL", 3'b111, 1, 0, 1, 0, 0);
      e = put(e, F_WR, 1, 3'b001);
      e = put(e, F_DB, 1, 3'b000);
      e = put(e, F_RD, 2, rtype ? 3'b010 : 3'b001);
      e = put(e, F_PCS, 2, 3'b000);
      seq.push_back(e);
      return;
    end
    case (op)
      6'b111000: seq.push_back(put(rec("ID_j", 3'b001, 1, 0, 0, 0, 0), F_PCS, 2, 3'b011));
      6'b111001: seq.push_back(put(rec("ID_jr", 3'b001, 1, 0, 0, 0, 0), F_PCS, 2, 3'b010));
      6'b111010: begin
        e = rec("ID_jal", 3'b001, 1, 0, 1, 0, 0);
        e = put(e, F_RD, 2, 3'b000);
        e = put(e, F_WR, 1, 3'b000);
        e = put(e, F_PCS, 2, 3'b011);
        seq.push_back(e);
      end
      6'b110100: begin
        seq.push_back(rec("ID_beq", 3'b001, 0, 0, 0, 0, 0));
        e = rec("EXE_BR", 3'b101, 1, 0, 0, 0, 0);
        e = put(e, F_ALUOP, 3, 3'b001);
        e = put(e, F_PCS, 2, z ? 3'b001 : 3'b000);
        seq.push_back(e);
      end
      6'b110000, 6'b110001: begin
        seq.push_back(rec("ID_ls", 3'b001, 0, 0, 0, 0, 0));
        e = rec("EXE_LS", 3'b010, 0, 0, 0, 0, 0);
        e = put(e, F_ALUOP, 3, 3'b000);
        e = put(e, F_SRCB, 1, 3'b001);
        e = put(e, F_EXT, 1, 3'b001);
        seq.push_back(e);
        if (op == 6'b110001) begin
          seq.push_back(rec("MEM_lw", 3'b011, 0, 0, 0, 1, 0));
          e = rec("WB_LD", 3'b100, 1, 0, 1, 0, 0);
          e = put(e, F_DB, 1, 3'b001);
          e = put(e, F_WR, 1, 3'b001);
          e = put(e, F_RD, 2, 3'b001);
          e = put(e, F_PCS, 2, 3'b000);
          seq.push_back(e);
        end else begin
          seq.push_back(put(rec("MEM_sw", 3'b011, 1, 0, 0, 0, 1), F_PCS, 2, 3'b000));
        end
      end
      default: begin
        seq_parks = 1'b1;
        for (int i = 0; i < HALT_HOLD; i++)
          seq.push_back(rec("ID_halt", 3'b001, 0, 0, 0, 0, 0));
      end
    endcase
  endfunction

  // Called just after a rising edge with the DUT in IF. abort_n > 0 asserts
  // Reset in cycle abort_n+1; abort_n < 0 picks a random abort point sometimes.
  task automatic run(input logic [5:0] op, input logic z, input int abort_n);
    int n, ab;
    model(op, z);
    ab = abort_n;
    if (ab < 0) ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, seq.size() - 1) : 0;
    n = (ab > 0) ? ab : seq.size();
    bus.opcode = op;
    bus.zero   = z;
    for (int i = 0; i < n; i++) sb_q.push_back(seq[i]);
    repeat (n) @(posedge CLK);
    #1;
    if (ab > 0 || seq_parks) begin
      Reset = 1'b1;
      sb_q.push_back(reset_rec("reset_mid"));
      @(posedge CLK);
      #1;
      Reset = 1'b0;
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    logic [19:0] obs;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      obs = {bus.state, bus.PCWre, bus.IRWre, bus.RegWre, bus.mRD, bus.mWR,
             bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel, bus.DBDataSrc,
             bus.WrRegDSrc, bus.RegDst, bus.PCSrc};
      n_checks++;
      if ((obs & e.m) !== (e.v & e.m))
        $display("FAIL %s: got %05h want %05h (mask %05h) at %0t",
                 e.tag, obs & e.m, e.v & e.m, e.m, $time);
      else
        n_pass++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  logic [5:0] ops [15] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                           6'b010010, 6'b011000, 6'b100110, 6'b100111, 6'b110000,
                           6'b110001, 6'b110100, 6'b111000, 6'b111001, 6'b111010};

  initial begin
    Reset = 1'b1;
    bus.opcode = 6'b000000;
    bus.zero   = 1'b0;
    @(posedge CLK);
    #1;
    sb_q.push_back(reset_rec("reset_init"));
    @(posedge CLK);
    #1;
    Reset = 1'b0;

    run(6'b000000, 1'b0, 0);   // add
    run(6'b000000, 1'b0, 3);   // add, Reset in WB_AL
    run(6'b110001, 1'b0, 0);   // lw
    run(6'b110000, 1'b0, 0);   // sw
    run(6'b110000, 1'b0, 3);   // sw, Reset in MEM
    run(6'b110100, 1'b1, 0);   // beq taken
    run(6'b110100, 1'b0, 0);   // beq not taken
    run(6'b111010, 1'b0, 0);   // jal
    run(6'b111001, 1'b0, 0);   // jr
    run(6'b111000, 1'b0, 0);   // j
    run(6'b011000, 1'b0, 0);   // sll
    run(6'b010010, 1'b0, 0);   // ori
    run(6'b111111, 1'b0, 0);   // halt
    run(6'b101010, 1'b0, 0);   // undefined
    run(6'b000010, 1'b0, 0);   // addi after recovery

    for (int i = 0; i < 80; i++)
      run(ops[$urandom_range(0, 14)], 1'($urandom_range(0, 1)), -1);

    repeat (2) @(posedge CLK);
    n_checks++;
    if (sb_q.size() != 0)
      $display("FAIL drain: got %0d pending entries want 0", sb_q.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
